// File: rtl/frontend_seq_pkg.sv
// frontend_seq shared types and helpers.
// State encoding, IRQ vector builder, round-robin picker.
package frontend_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGGER,
    S_RUN
  } state_e;

  localparam logic [30:0] IRQ_IP_HI = 31'd1;
  localparam int          IRQ_W     = 4;
  localparam int          IP_W      = 42;
  localparam int          MAXC      = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;

  function automatic logic [IP_W-1:0] mk_irq_ip(
    input logic [IRQ_W-1:0] num
  );
    return {IRQ_IP_HI, num, 7'b0};
  endfunction

  // mask bit 1 = not eligible; lowest offset from rr wins
  function automatic pick_t rr_pick(
    input logic [MAXC-1:0] mask,
    input logic [5:0]      rr,
    input int              n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = MAXC - 1; i >= 0; i--) begin
      j = int'(rr) + i;
      if (j >= n) j = j - n;
      if (i < n && !mask[j[5:0]]) begin
        p.found = 1'b1;
        p.idx   = j[5:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/frontend_seq_if.sv
// IRQ request/dispatch bundle.
// master = tile side, slave = sequencer.
interface frontend_seq_if #(
  parameter int NCORE = 36,
  parameter int CW    = 6
);
  logic             irqload;
  logic [3:0]       irqnum;
  logic [NCORE-1:0] irq_mask;
  logic [NCORE-1:0] irq_ack;
  logic             irq_valid;
  logic [CW-1:0]    irq_core;
  logic [41:0]      irq_IP;
  logic             irq_ovf;

  modport master (
    output irqload, irqnum, irq_mask, irq_ack,
    input  irq_valid, irq_core, irq_IP, irq_ovf
  );

  modport slave (
    input  irqload, irqnum, irq_mask, irq_ack,
    output irq_valid, irq_core, irq_IP, irq_ovf
  );
endinterface

// File: rtl/frontend_seq_irq_fifo.sv
// Small sync FIFO holding pending IRQ numbers.
// Exposes head and head+1 for back-to-back dispatch.
module irq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [WIDTH-1:0] o_next,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_two
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_nxt;

  assign o_full   = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty  = (r_cnt == '0);
  assign o_two    = (r_cnt >= (AW+1)'(2));
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign w_rd_nxt = r_rd + AW'(1);
  assign o_head   = r_mem[r_rd];
  assign o_next   = r_mem[w_rd_nxt];

  // storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= w_rd_nxt;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/frontend_seq.sv
// Tile frontend sequencer: staggered core reset release,
// queued round-robin IRQ dispatch, stall aggregation.
import frontend_seq_pkg::*;

module frontend_seq #(
  parameter int NCORE      = 36,
  parameter int NSTALL     = 12,
  parameter int RST_STAGES = 5,
  parameter int STAGGER    = 2,
  parameter int IRQ_DEPTH  = 4,
  parameter int CW         = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  frontend_seq_if.slave           bus,
  input  logic [NCORE*NSTALL-1:0] resource_stall,
  output logic [NCORE-1:0]        core_rst,
  output logic                    all_up,
  output logic [NSTALL-1:0]       resource_stallx
);

  state_e             r_state, w_state_nxt;
  logic [15:0]        r_cnt, w_cnt_nxt;
  logic [CW-1:0]      r_idx, w_idx_nxt;
  logic [NCORE-1:0]   r_core_rst, w_rst_nxt;

  logic               r_valid;
  logic [CW-1:0]      r_core;
  logic [IP_W-1:0]    r_ip;
  logic               r_ovf;
  logic [CW-1:0]      r_rr;
  logic [NSTALL-1:0]  r_stallx;
  logic [NSTALL-1:0]  w_stall;

  logic [NCORE-1:0]   w_core_oh;
  logic               w_ack;
  logic               w_have;
  logic               w_load;
  logic [CW-1:0]      w_core_inc;
  logic [CW-1:0]      w_rr_eff;
  pick_t              w_pick;
  logic [IRQ_W-1:0]   w_head;
  logic [IRQ_W-1:0]   w_next;
  logic [IRQ_W-1:0]   w_data;
  logic               w_full;
  logic               w_empty;
  logic               w_two;

  // release state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_core_rst <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_core_rst <= w_rst_nxt;
    end
  end

  // settle, then release one core every STAGGER edges
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_core_rst;
    unique case (r_state)
      S_HOLD: begin
        if (r_cnt == 16'(RST_STAGES - 1)) begin
          w_state_nxt = S_STAGGER;
          w_cnt_nxt   = '0;
        end
      end
      S_STAGGER: begin
        if (r_cnt == 16'(STAGGER - 1)) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + CW'(1);
          for (int k = 0; k < NCORE; k++) begin
            if (CW'(k) == r_idx) w_rst_nxt[k] = 1'b0;
          end
          if (r_idx == CW'(NCORE - 1)) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt;
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  irq_fifo #(
    .DEPTH (IRQ_DEPTH),
    .WIDTH (IRQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.irqload),
    .i_pop   (w_ack),
    .i_data  (bus.irqnum),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_two   (w_two)
  );

  // ack only counts from the presented core; head is
  // popped on ack, so a back-to-back load takes head+1
  assign w_core_oh  = {{(NCORE-1){1'b0}}, 1'b1} << r_core;
  assign w_ack      = r_valid && |(bus.irq_ack & w_core_oh);
  assign w_core_inc = (r_core == CW'(NCORE - 1))
                    ? '0 : r_core + CW'(1);
  assign w_rr_eff   = w_ack ? w_core_inc : r_rr;
  assign w_pick     = rr_pick(MAXC'(bus.irq_mask),
                              6'(w_rr_eff), NCORE);
  assign w_have     = w_ack ? w_two : !w_empty;
  assign w_data     = w_ack ? w_next : w_head;
  assign w_load     = (r_state == S_RUN)
                   && (!r_valid || w_ack)
                   && w_have && w_pick.found;

  // dispatch register, round-robin pointer, overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_core  <= '0;
      r_ip    <= '0;
      r_ovf   <= 1'b0;
      r_rr    <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_core  <= CW'(w_pick.idx);
        r_ip    <= mk_irq_ip(w_data);
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end
      if (w_ack) r_rr <= w_core_inc;
      if (bus.irqload && w_full && !w_ack) r_ovf <= 1'b1;
    end
  end

  // OR of stall vectors from cores already out of reset
  always_comb begin
    w_stall = '0;
    for (int c = 0; c < NCORE; c++) begin
      w_stall = w_stall
              | (resource_stall[c*NSTALL +: NSTALL]
                 & {NSTALL{~r_core_rst[c]}});
    end
  end

  // registered stall summary
  always_ff @(posedge clk) begin
    if (!rst_n) r_stallx <= '0;
    else        r_stallx <= w_stall;
  end

  assign core_rst        = r_core_rst;
  assign all_up          = (r_state == S_RUN);
  assign resource_stallx = r_stallx;
  assign bus.irq_valid   = r_valid;
  assign bus.irq_core    = r_core;
  assign bus.irq_IP      = r_ip;
  assign bus.irq_ovf     = r_ovf;

endmodule

// File: tb/tb_frontend_seq.sv
// Directed bench for frontend_seq with NCORE=4.
// Outputs sampled 1 time unit after each rising edge.
module tb_frontend_seq;

  localparam int NC = 4;
  localparam int NS = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC*NS-1:0] rs;
  logic [NC-1:0] core_rst;
  logic          all_up;
  logic [NS-1:0] stallx;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] nums [5];

  frontend_seq_if #(.NCORE(NC), .CW(2)) bus ();

  frontend_seq #(
    .NCORE      (NC),
    .NSTALL     (NS),
    .RST_STAGES (5),
    .STAGGER    (2),
    .IRQ_DEPTH  (4),
    .CW         (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .resource_stall  (rs),
    .core_rst        (core_rst),
    .all_up          (all_up),
    .resource_stallx (stallx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] bip(input logic [3:0] n);
    return {31'd1, n, 7'b0};
  endfunction

  function automatic logic [3:0] exp_rst(input int e);
    if (e >= 13) return 4'h0;
    if (e >= 11) return 4'h8;
    if (e >= 9)  return 4'hC;
    if (e >= 7)  return 4'hE;
    return 4'hF;
  endfunction

  task automatic chk_reset_outs();
    chk("rst core_rst", core_rst, 4'hF);
    chk("rst all_up", all_up, 1'b0);
    chk("rst valid", bus.irq_valid, 1'b0);
    chk("rst core", bus.irq_core, 2'd0);
    chk("rst ip", bus.irq_IP, 42'd0);
    chk("rst ovf", bus.irq_ovf, 1'b0);
    chk("rst stallx", stallx, 12'h0);
  endtask

  task automatic push(input logic [3:0] n);
    bus.irqload = 1'b1;
    bus.irqnum  = n;
    tick();
    bus.irqload = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    rs           = '0;
    bus.irqload  = 1'b0;
    bus.irqnum   = 4'd0;
    bus.irq_mask = '0;
    bus.irq_ack  = '0;
    nums[0] = 4'd1; nums[1] = 4'd2; nums[2] = 4'd3;
    nums[3] = 4'd4; nums[4] = 4'd6;

    repeat (3) tick();
    chk_reset_outs();

    // release sequence with stall masking
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk("rel core_rst", core_rst, exp_rst(e));
      chk("rel all_up", all_up, e >= 13);
      chk("rel stallx", stallx, (e >= 8) ? 12'h001 : 12'h0);
      if (e == 7) begin
        rs[11:0]  = 12'h001;
        rs[47:36] = 12'h800;
      end
    end
    tick();
    chk("stall core3 in", stallx, 12'h801);
    rs = '0;

    // single IRQ, foreign ack ignored
    push(4'd3);
    chk("irq lat0", bus.irq_valid, 1'b0);
    tick();
    chk("irq valid", bus.irq_valid, 1'b1);
    chk("irq core0", bus.irq_core, 2'd0);
    chk("irq ip3", bus.irq_IP, bip(4'd3));
    bus.irq_ack = 4'b0010;
    tick();
    chk("foreign ack valid", bus.irq_valid, 1'b1);
    chk("foreign ack core", bus.irq_core, 2'd0);
    chk("foreign ack ip", bus.irq_IP, bip(4'd3));
    bus.irq_ack = 4'b0001;
    tick();
    chk("ack0 drop", bus.irq_valid, 1'b0);
    bus.irq_ack = '0;
    push(4'd5);
    tick();
    chk("rr valid", bus.irq_valid, 1'b1);
    chk("rr core1", bus.irq_core, 2'd1);
    chk("rr ip5", bus.irq_IP, bip(4'd5));
    bus.irq_ack = 4'b0010;
    tick();
    chk("ack1 drop", bus.irq_valid, 1'b0);
    bus.irq_ack = '0;

    // overflow with all cores masked
    bus.irq_mask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      push(nums[i]);
      chk("ovf flag", bus.irq_ovf, i == 4);
    end
    tick();
    chk("masked wait", bus.irq_valid, 1'b0);
    bus.irq_mask = 4'b1011;
    tick();
    for (int j = 0; j < 4; j++) begin
      chk("ovf dl valid", bus.irq_valid, 1'b1);
      chk("ovf dl core2", bus.irq_core, 2'd2);
      chk("ovf dl ip", bus.irq_IP, bip(nums[j]));
      chk("ovf sticky", bus.irq_ovf, 1'b1);
      bus.irq_ack = 4'b0100;
      tick();
      bus.irq_ack = '0;
    end
    chk("ovf drained", bus.irq_valid, 1'b0);
    chk("ovf sticky end", bus.irq_ovf, 1'b1);

    // back-to-back, core 3 masked so rr=3 wraps to 0
    bus.irq_mask = 4'b1000;
    push(4'd7);
    push(4'd8);
    chk("b2b v0", bus.irq_valid, 1'b1);
    chk("b2b core0", bus.irq_core, 2'd0);
    chk("b2b ip7", bus.irq_IP, bip(4'd7));
    bus.irq_ack = 4'hF;
    tick();
    chk("b2b v1", bus.irq_valid, 1'b1);
    chk("b2b core1", bus.irq_core, 2'd1);
    chk("b2b ip8", bus.irq_IP, bip(4'd8));
    tick();
    chk("b2b drop", bus.irq_valid, 1'b0);
    bus.irq_ack = '0;

    // reset mid-operation
    bus.irq_mask = '0;
    push(4'd9);
    push(4'd10);
    push(4'd11);
    chk("mid valid", bus.irq_valid, 1'b1);
    chk("mid core2", bus.irq_core, 2'd2);
    rst_n = 1'b0;
    tick();
    chk_reset_outs();
    rst_n = 1'b1;
    rs    = '1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk("rel2 core_rst", core_rst, exp_rst(e));
      chk("rel2 no stale", bus.irq_valid, 1'b0);
      chk("rel2 stallx", stallx, (e >= 8) ? 12'hFFF : 12'h0);
    end
    rs = '0;
    repeat (2) tick();
    chk("post rst idle", bus.irq_valid, 1'b0);
    chk("post rst ovf", bus.irq_ovf, 1'b0);
    push(4'd12);
    tick();
    chk("post rst valid", bus.irq_valid, 1'b1);
    chk("post rst core0", bus.irq_core, 2'd0);
    chk("post rst ip", bus.irq_IP, bip(4'd12));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
